tcp_rt_req_queue: RTL and testbench
===================================

# tcp_rt_req_queue

Per-flow retransmit request queue sitting directly downstream of the TCP slow-path ACK processing stage. Consumes each processed ACK's flow ID, retransmit flag and new TX head pointer. Records at most one outstanding retransmit request per flow and keeps the request's head pointer current as later ACKs arrive. Hands requests in arrival order to the TX send engine over a val/rdy handshake.

## Interface
Parameters:
- FLOWID_W, default 3: flow ID width; NUM_FLOWS = 2**FLOWID_W.
- PTR_W, default TX_PAYLOAD_PTR_W+1 (tcp_pkg): head pointer width.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- ack_rt_val  in  1  ACK-stage result valid.
- ack_rt_flowid  in  FLOWID_W  flow of the result.
- ack_rt_set_rt  in  1  ACK stage hit the duplicate-ACK threshold.
- ack_rt_head_ptr  in  PTR_W  new TX head pointer (next ACK number, low bits).
- ack_rt_rdy  out  1  constant 1 out of reset; the queue never back-pressures.
- flow_clear_val  in  1  connection teardown.
- flow_clear_flowid  in  FLOWID_W  flow being torn down.
- rt_req_val  out  1  retransmit request valid.
- rt_req_flowid  out  FLOWID_W  flow to retransmit.
- rt_req_head_ptr  out  PTR_W  pointer to retransmit from.
- rt_req_rdy  in  1  TX engine accepts the request.
- pending_cnt  out  FLOWID_W+1  number of flows with pending=1.

## Operation
Per-flow state (registers, NUM_FLOWS entries):
- pending: request outstanding.
- queued: flow ID present in the FIFO.
- head_ptr[PTR_W].

FIFO of flow IDs has depth NUM_FLOWS. The queued bit guarantees one entry per flow, so the FIFO cannot overflow and has no full check.

Input handling (every cycle ack_rt_val=1):
- set_rt=1, queued=0: set pending and queued, store head_ptr, push flowid.
- set_rt=1, queued=1: set pending, store head_ptr, no push.
- set_rt=0, pending=1: store head_ptr (refresh only).
- set_rt=0, pending=0: no effect.

Clear: flow_clear_val clears pending for the flow. queued and the FIFO entry are left as-is; the entry becomes stale.

Output (FIFO head flow h):
- Head valid (FIFO non-empty and pending[h]=1): rt_req_val=1, rt_req_flowid=h, rt_req_head_ptr=head_ptr[h] (combinational read of the register). Handshake rt_req_val&rt_req_rdy pops the FIFO and clears pending[h] and queued[h].
- Head stale (FIFO non-empty, pending[h]=0): rt_req_val=0, and the entry is popped silently that cycle, clearing queued[h].

Simultaneous events, same flow, same cycle (in priority order):
- Clear beats input: the flow ends with pending=0. The ACK is dropped, and head_ptr is still written.
- Pop plus input set_rt=1: pop takes effect first, then the input re-arms the flow. Result: pending=1, queued=1, pushed again, new head_ptr.
- Pop plus input set_rt=0: pop takes effect, and the input is then a no-op (flow no longer pending).

FIFO push and pop in the same cycle are both legal, including when the FIFO is empty-to-one or at NUM_FLOWS occupancy.

pending_cnt is registered and tracks the pending bits after each cycle's updates.

## Timing
- Reset values: all pending/queued 0, FIFO empty, head_ptr 0, rt_req_val 0, rt_req_flowid 0, rt_req_head_ptr 0, pending_cnt 0, ack_rt_rdy 0 during rst and 1 from the first cycle after.
- Latency: an input with set_rt accepted in cycle N gives rt_req_val=1 in cycle N+1 at the earliest (FIFO previously empty).
- A head_ptr refresh in cycle N is visible on rt_req_head_ptr in N+1.
- rt_req_val and its payload hold stable until the handshake. The exception is rt_req_head_ptr, which follows refreshes, and the TX engine samples it at the handshake. A clear of the head flow drops rt_req_val in the next cycle.
- A stale head costs one bubble cycle.
- Throughput: one request per cycle.
- rst mid-operation discards all pending requests within one cycle.

## Structure
- tcp_pkg already holds TX_PAYLOAD_PTR_W. Add FLOWID_W there if not already shared, plus a struct rt_req_struct {flowid, head_ptr} for the output bundle.
- Sub-module: rt_flowid_fifo, a generic register FIFO (parameters width, log2 depth). It has push/pop, empty, and a head-data output, and supports simultaneous push/pop.
- The per-flow arrays and the arbitration logic stay in the top module.

## Test plan
- Single request: set_rt flow 2, ptr 0x40 in cycle 0 -> cycle 1 rt_req_val=1, flowid 2, ptr 0x40. rdy=1 -> pending_cnt back to 0.
- Coalesce and refresh: set_rt flow 1 ptr 0x10, then set_rt flow 1 ptr 0x18, then set_rt=0 ptr 0x20, rdy held 0 -> exactly one request, ptr 0x20. pending_cnt=1 throughout.
- Ordering and depth: set_rt flows 7..0 in consecutive cycles with rdy=0, then rdy=1 -> requests 7,6,…,0 on eight consecutive cycles with no drop.
- Stale skip: set_rt flows 3 then 5, clear flow 3 -> flow 5 is presented after one bubble, and flow 3 never appears.
- Re-arm after clear: set_rt flow 4, clear flow 4, set_rt flow 4 ptr 0x30 while still queued -> single flow-4 request with ptr 0x30.
- Collisions: handshake on flow 6 in the same cycle as set_rt flow 6 -> second request for flow 6 next cycle. Clear and set_rt on flow 6 in the same cycle -> no request. Assert rst mid-burst -> rt_req_val=0 next cycle and pending_cnt=0.

Source files
------------

// File: rtl/tcp_pkg.sv
// Shared TCP datapath widths and the retransmit request bundle type.
package tcp_pkg;
  localparam int TX_PAYLOAD_PTR_W = 7;
  localparam int FLOWID_W         = 3;

  typedef struct packed {
    logic [FLOWID_W-1:0]         flowid;
    logic [TX_PAYLOAD_PTR_W:0]   head_ptr;
  } rt_req_struct;
endpackage

// File: rtl/rt_flowid_fifo.sv
// Generic register FIFO with a combinational head output; push and pop may coincide,
// including at empty and at full occupancy.
module rt_flowid_fifo #(
  parameter int WIDTH      = 3,
  parameter int LOG2_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);
  localparam int DEPTH = 2 ** LOG2_DEPTH;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [LOG2_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0] rd_ptr_q, rd_ptr_d;

  // Extra pointer bit distinguishes full from empty; only empty is needed here.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign head_dat = mem_q[rd_ptr_q[LOG2_DEPTH-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[LOG2_DEPTH-1:0]] = push_dat;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/tcp_rt_req_queue.sv
// Per-flow retransmit request queue: one outstanding request per flow, head pointer kept
// current by later ACKs, requests issued in arrival order over val/rdy; never back-pressures.
module tcp_rt_req_queue
  import tcp_pkg::*;
#(
  parameter int FLOWID_W = tcp_pkg::FLOWID_W,
  parameter int PTR_W    = TX_PAYLOAD_PTR_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ack_rt_val,
  input  logic [FLOWID_W-1:0] ack_rt_flowid,
  input  logic                ack_rt_set_rt,
  input  logic [PTR_W-1:0]    ack_rt_head_ptr,
  output logic                ack_rt_rdy,
  input  logic                flow_clear_val,
  input  logic [FLOWID_W-1:0] flow_clear_flowid,
  output logic                rt_req_val,
  output logic [FLOWID_W-1:0] rt_req_flowid,
  output logic [PTR_W-1:0]    rt_req_head_ptr,
  input  logic                rt_req_rdy,
  output logic [FLOWID_W:0]   pending_cnt
);
  localparam int NUM_FLOWS = 2 ** FLOWID_W;

  logic [NUM_FLOWS-1:0] pending_q, pending_d;
  logic [NUM_FLOWS-1:0] queued_q, queued_d;
  logic [PTR_W-1:0]     head_ptr_q [NUM_FLOWS];
  logic [PTR_W-1:0]     head_ptr_d [NUM_FLOWS];
  logic [FLOWID_W:0]    pending_cnt_q, pending_cnt_d;
  logic                 rdy_q;

  logic                fifo_empty;
  logic [FLOWID_W-1:0] head_flow;
  logic                head_vld;
  logic                fifo_pop;
  logic                fifo_push;

  rt_flowid_fifo #(
    .WIDTH      (FLOWID_W),
    .LOG2_DEPTH (FLOWID_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (ack_rt_flowid),
    .pop      (fifo_pop),
    .empty    (fifo_empty),
    .head_dat (head_flow)
  );

  assign head_vld = !fifo_empty && pending_q[head_flow];
  // Stale heads are dropped without waiting for the TX engine.
  assign fifo_pop = !fifo_empty && (!pending_q[head_flow] || rt_req_rdy);

  assign rt_req_val      = head_vld;
  assign rt_req_flowid   = head_vld ? head_flow : '0;
  assign rt_req_head_ptr = head_vld ? head_ptr_q[head_flow] : '0;
  assign pending_cnt     = pending_cnt_q;
  assign ack_rt_rdy      = rdy_q;

  always_comb begin
    pending_d     = pending_q;
    queued_d      = queued_q;
    head_ptr_d    = head_ptr_q;
    fifo_push     = 1'b0;
    pending_cnt_d = '0;

    if (fifo_pop) begin
      pending_d[head_flow] = 1'b0;
      queued_d[head_flow]  = 1'b0;
    end

    // Input sees post-pop state so a popped flow can be re-armed in the same cycle.
    if (ack_rt_val) begin
      if (ack_rt_set_rt) begin
        pending_d[ack_rt_flowid]  = 1'b1;
        head_ptr_d[ack_rt_flowid] = ack_rt_head_ptr;
        if (!queued_d[ack_rt_flowid]) begin
          queued_d[ack_rt_flowid] = 1'b1;
          fifo_push               = 1'b1;
        end
      end else if (pending_d[ack_rt_flowid]) begin
        head_ptr_d[ack_rt_flowid] = ack_rt_head_ptr;
      end
    end

    if (flow_clear_val) begin
      pending_d[flow_clear_flowid] = 1'b0;
    end

    for (int i = 0; i < NUM_FLOWS; i++) begin
      pending_cnt_d = pending_cnt_d + (FLOWID_W + 1)'(pending_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      queued_q      <= '0;
      pending_cnt_q <= '0;
      rdy_q         <= 1'b0;
      for (int i = 0; i < NUM_FLOWS; i++) head_ptr_q[i] <= '0;
    end else begin
      pending_q     <= pending_d;
      queued_q      <= queued_d;
      pending_cnt_q <= pending_cnt_d;
      rdy_q         <= 1'b1;
      head_ptr_q    <= head_ptr_d;
    end
  end
endmodule

// File: tb/tb_tcp_rt_req_queue.sv
// Directed bench for tcp_rt_req_queue: inputs change and outputs are sampled 1ns after posedge.
module tb_tcp_rt_req_queue;
  logic       clk = 1'b0;
  logic       rst;
  logic       ack_rt_val;
  logic [2:0] ack_rt_flowid;
  logic       ack_rt_set_rt;
  logic [7:0] ack_rt_head_ptr;
  logic       ack_rt_rdy;
  logic       flow_clear_val;
  logic [2:0] flow_clear_flowid;
  logic       rt_req_val;
  logic [2:0] rt_req_flowid;
  logic [7:0] rt_req_head_ptr;
  logic       rt_req_rdy;
  logic [3:0] pending_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcp_rt_req_queue dut (
    .clk               (clk),
    .rst               (rst),
    .ack_rt_val        (ack_rt_val),
    .ack_rt_flowid     (ack_rt_flowid),
    .ack_rt_set_rt     (ack_rt_set_rt),
    .ack_rt_head_ptr   (ack_rt_head_ptr),
    .ack_rt_rdy        (ack_rt_rdy),
    .flow_clear_val    (flow_clear_val),
    .flow_clear_flowid (flow_clear_flowid),
    .rt_req_val        (rt_req_val),
    .rt_req_flowid     (rt_req_flowid),
    .rt_req_head_ptr   (rt_req_head_ptr),
    .rt_req_rdy        (rt_req_rdy),
    .pending_cnt       (pending_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ack_rt_val     = 1'b0;
    ack_rt_set_rt  = 1'b0;
    flow_clear_val = 1'b0;
  endtask

  task automatic ack(input logic [2:0] f, input logic set_rt, input logic [7:0] p);
    ack_rt_val      = 1'b1;
    ack_rt_flowid   = f;
    ack_rt_set_rt   = set_rt;
    ack_rt_head_ptr = p;
  endtask

  task automatic clr(input logic [2:0] f);
    flow_clear_val    = 1'b1;
    flow_clear_flowid = f;
  endtask

  task automatic test_reset();
    rst = 1'b1; rt_req_rdy = 1'b0; ack_rt_flowid = '0; ack_rt_head_ptr = '0;
    flow_clear_flowid = '0; idle();
    cyc(); cyc();
    checks++; if (rt_req_val !== 1'b0) begin errors++; $display("FAIL reset_val got %0h want 0", rt_req_val); end
    checks++; if (rt_req_flowid !== 3'd0) begin errors++; $display("FAIL reset_flowid got %0h want 0", rt_req_flowid); end
    checks++; if (rt_req_head_ptr !== 8'd0) begin errors++; $display("FAIL reset_ptr got %0h want 0", rt_req_head_ptr); end
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", pending_cnt); end
    checks++; if (ack_rt_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %0h want 0", ack_rt_rdy); end
    rst = 1'b0;
    cyc();
    checks++; if (ack_rt_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_rdy got %0h want 1", ack_rt_rdy); end
    checks++; if (rt_req_val !== 1'b0) begin errors++; $display("FAIL post_reset_val got %0h want 0", rt_req_val); end
  endtask

  task automatic test_single();
    ack(3'd2, 1'b1, 8'h40);
    cyc(); idle();
    checks++; if (rt_req_val !== 1'b1) begin errors++; $display("FAIL single_val got %0h want 1", rt_req_val); end
    checks++; if (rt_req_flowid !== 3'd2) begin errors++; $display("FAIL single_flowid got %0d want 2", rt_req_flowid); end
    checks++; if (rt_req_head_ptr !== 8'h40) begin errors++; $display("FAIL single_ptr got %0h want 40", rt_req_head_ptr); end
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", pending_cnt); end
    rt_req_rdy = 1'b1;
    cyc(); rt_req_rdy = 1'b0;
    checks++; if (rt_req_val !== 1'b0) begin errors++; $display("FAIL single_done_val got %0h want 0", rt_req_val); end
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL single_done_cnt got %0d want 0", pending_cnt); end
  endtask

  task automatic test_coalesce();
    ack(3'd1, 1'b1, 8'h10);
    cyc();
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL coal_cnt0 got %0d want 1", pending_cnt); end
    checks++; if (rt_req_head_ptr !== 8'h10) begin errors++; $display("FAIL coal_ptr0 got %0h want 10", rt_req_head_ptr); end
    ack(3'd1, 1'b1, 8'h18);
    cyc();
    checks++; if (rt_req_head_ptr !== 8'h18) begin errors++; $display("FAIL coal_ptr1 got %0h want 18", rt_req_head_ptr); end
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL coal_cnt1 got %0d want 1", pending_cnt); end
    ack(3'd1, 1'b0, 8'h20);
    cyc(); idle();
    checks++; if (rt_req_val !== 1'b1 || rt_req_flowid !== 3'd1) begin errors++; $display("FAIL coal_req got val %0h flow %0d want val 1 flow 1", rt_req_val, rt_req_flowid); end
    checks++; if (rt_req_head_ptr !== 8'h20) begin errors++; $display("FAIL coal_ptr2 got %0h want 20", rt_req_head_ptr); end
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL coal_cnt2 got %0d want 1", pending_cnt); end
    rt_req_rdy = 1'b1;
    cyc(); rt_req_rdy = 1'b0;
    checks++; if (rt_req_val !== 1'b0) begin errors++; $display("FAIL coal_single got val %0h want 0", rt_req_val); end
    cyc();
    checks++; if (rt_req_val !== 1'b0 || pending_cnt !== 4'd0) begin errors++; $display("FAIL coal_empty got val %0h cnt %0d want 0 0", rt_req_val, pending_cnt); end
  endtask

  task automatic test_order();
    for (int f = 7; f >= 0; f--) begin
      ack(3'(f), 1'b1, 8'h80 + 8'(f));
      cyc();
    end
    idle();
    checks++; if (pending_cnt !== 4'd8) begin errors++; $display("FAIL order_cnt got %0d want 8", pending_cnt); end
    rt_req_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rt_req_val !== 1'b1 || rt_req_flowid !== 3'(7 - k) || rt_req_head_ptr !== 8'h80 + 8'(7 - k)
          || pending_cnt !== 4'(8 - k)) begin
        errors++;
        $display("FAIL order_%0d got val %0h flow %0d ptr %0h cnt %0d want 1 %0d %0h %0d",
                 k, rt_req_val, rt_req_flowid, rt_req_head_ptr, pending_cnt, 7 - k, 8'h80 + 8'(7 - k), 8 - k);
      end
      cyc();
    end
    rt_req_rdy = 1'b0;
    checks++; if (rt_req_val !== 1'b0 || pending_cnt !== 4'd0) begin errors++; $display("FAIL order_drained got val %0h cnt %0d want 0 0", rt_req_val, pending_cnt); end
  endtask

  task automatic test_stale();
    ack(3'd3, 1'b1, 8'h33);
    cyc();
    ack(3'd5, 1'b1, 8'h55);
    cyc(); idle();
    checks++; if (rt_req_val !== 1'b1 || rt_req_flowid !== 3'd3) begin errors++; $display("FAIL stale_head got val %0h flow %0d want 1 3", rt_req_val, rt_req_flowid); end
    clr(3'd3);
    cyc(); idle();
    checks++; if (rt_req_val !== 1'b0) begin errors++; $display("FAIL stale_bubble got val %0h want 0", rt_req_val); end
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL stale_cnt got %0d want 1", pending_cnt); end
    cyc();
    checks++; if (rt_req_val !== 1'b1 || rt_req_flowid !== 3'd5 || rt_req_head_ptr !== 8'h55) begin errors++; $display("FAIL stale_next got val %0h flow %0d ptr %0h want 1 5 55", rt_req_val, rt_req_flowid, rt_req_head_ptr); end
    rt_req_rdy = 1'b1;
    cyc(); rt_req_rdy = 1'b0;
    checks++; if (rt_req_val !== 1'b0 || pending_cnt !== 4'd0) begin errors++; $display("FAIL stale_end got val %0h cnt %0d want 0 0", rt_req_val, pending_cnt); end
  endtask

  task automatic test_rearm();
    ack(3'd0, 1'b1, 8'h01);
    cyc();
    ack(3'd4, 1'b1, 8'h11);
    cyc(); idle();
    clr(3'd4);
    cyc(); idle();
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL rearm_clr_cnt got %0d want 1", pending_cnt); end
    ack(3'd4, 1'b1, 8'h30);
    cyc(); idle();
    checks++; if (pending_cnt !== 4'd2) begin errors++; $display("FAIL rearm_cnt got %0d want 2", pending_cnt); end
    checks++; if (rt_req_val !== 1'b1 || rt_req_flowid !== 3'd0) begin errors++; $display("FAIL rearm_head got val %0h flow %0d want 1 0", rt_req_val, rt_req_flowid); end
    rt_req_rdy = 1'b1;
    cyc();
    checks++; if (rt_req_val !== 1'b1 || rt_req_flowid !== 3'd4 || rt_req_head_ptr !== 8'h30) begin errors++; $display("FAIL rearm_req got val %0h flow %0d ptr %0h want 1 4 30", rt_req_val, rt_req_flowid, rt_req_head_ptr); end
    cyc(); rt_req_rdy = 1'b0;
    checks++; if (rt_req_val !== 1'b0 || pending_cnt !== 4'd0) begin errors++; $display("FAIL rearm_end got val %0h cnt %0d want 0 0", rt_req_val, pending_cnt); end
    cyc();
    checks++; if (rt_req_val !== 1'b0) begin errors++; $display("FAIL rearm_dup got val %0h want 0", rt_req_val); end
  endtask

  task automatic test_collide();
    ack(3'd6, 1'b1, 8'h60);
    cyc();
    checks++; if (rt_req_val !== 1'b1 || rt_req_flowid !== 3'd6) begin errors++; $display("FAIL coll_first got val %0h flow %0d want 1 6", rt_req_val, rt_req_flowid); end
    rt_req_rdy = 1'b1;
    ack(3'd6, 1'b1, 8'h66);
    cyc(); idle(); rt_req_rdy = 1'b0;
    checks++; if (rt_req_val !== 1'b1 || rt_req_flowid !== 3'd6 || rt_req_head_ptr !== 8'h66) begin errors++; $display("FAIL coll_second got val %0h flow %0d ptr %0h want 1 6 66", rt_req_val, rt_req_flowid, rt_req_head_ptr); end
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL coll_cnt got %0d want 1", pending_cnt); end
    rt_req_rdy = 1'b1;
    cyc(); rt_req_rdy = 1'b0;
    checks++; if (rt_req_val !== 1'b0 || pending_cnt !== 4'd0) begin errors++; $display("FAIL coll_drain got val %0h cnt %0d want 0 0", rt_req_val, pending_cnt); end
    ack(3'd6, 1'b1, 8'h77);
    clr(3'd6);
    cyc(); idle();
    checks++; if (rt_req_val !== 1'b0 || pending_cnt !== 4'd0) begin errors++; $display("FAIL clr_set got val %0h cnt %0d want 0 0", rt_req_val, pending_cnt); end
    cyc();
    checks++; if (rt_req_val !== 1'b0) begin errors++; $display("FAIL clr_set_later got val %0h want 0", rt_req_val); end
    for (int f = 1; f <= 3; f++) begin
      ack(3'(f), 1'b1, 8'(f));
      cyc();
    end
    idle();
    checks++; if (pending_cnt !== 4'd3) begin errors++; $display("FAIL burst_cnt got %0d want 3", pending_cnt); end
    rst = 1'b1;
    cyc();
    checks++; if (rt_req_val !== 1'b0 || pending_cnt !== 4'd0) begin errors++; $display("FAIL mid_rst got val %0h cnt %0d want 0 0", rt_req_val, pending_cnt); end
    rst = 1'b0;
    cyc();
    checks++; if (rt_req_val !== 1'b0 || ack_rt_rdy !== 1'b1) begin errors++; $display("FAIL after_rst got val %0h rdy %0h want 0 1", rt_req_val, ack_rt_rdy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_coalesce();
    test_order();
    test_stale();
    test_rearm();
    test_collide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
